keypad_scan: RTL

KEYPAD_SCAN -- requirements
Module: keypad_scan

---
 rtl/keypad_pkg.sv | 30 +++
 rtl/keypad_fifo.sv | 53 +++++
 rtl/keypad_scan.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared constants, FSM state type and small helpers for the 4x5 keypad scanner.
package keypad_pkg;

    localparam int unsigned NUM_COLS   = 5;
    localparam int unsigned NUM_ROWS   = 4;
    localparam int unsigned CODE_W     = 5;
    localparam int unsigned FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        StScan,
        StPressDb,
        StHeld,
        StRelDb
    } state_t;

    // Lowest-indexed row that is pulled low; 0 when none is low.
    function automatic logic [1:0] lowest_row(input logic [NUM_ROWS-1:0] row_n);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            if (!row_n[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    function automatic logic [2:0] next_col(input logic [2:0] col);
        return (col == 3'(NUM_COLS - 1)) ? 3'd0 : col + 3'd1;
    endfunction

endpackage

// File: rtl/keypad_fifo.sv
// Small code FIFO for the keypad scanner; head output holds the last shown code
// once the FIFO drains so the consumer never sees stale slot contents.
module keypad_fifo
    import keypad_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [CODE_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              not_empty,
    output logic [CODE_W-1:0] head
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [CODE_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [CODE_W-1:0] last_q;
    logic              do_push, do_pop;

    assign full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign not_empty = (count_q != '0);
    assign do_pop    = pop && not_empty;
    assign do_push   = push && (!full || do_pop);
    assign head      = not_empty ? mem_q[rd_ptr_q] : last_q;

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (do_push && !do_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count_q <= count_q - CNT_W'(1);
            end
            if (not_empty) last_q <= mem_q[rd_ptr_q];
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// 4x5 matrix keypad scanner with debounce and a consumer read handshake.
// Define KEYPAD_FIFO_EN to buffer codes in a 4-entry FIFO instead of one register.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned DEBOUNCE_CNT = 250000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_ROWS-1:0] key_row,
    output logic [NUM_COLS-1:0] key_col,
    input  logic                readn,
    output logic [CODE_W-1:0]   key_code,
    output logic                key_ready,
    output logic                overrun
);

    localparam int unsigned SCAN_W = $clog2(SCAN_DIV + 1);
    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CNT - 1);

    state_t              state_q, state_d;
    logic [NUM_ROWS-1:0] row_s1_q, row_s2_q;
    logic [2:0]          col_q, col_d;
    logic [1:0]          row_sel_q, row_sel_d;
    logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
    logic [DB_W-1:0]     db_cnt_q, db_cnt_d;
    logic                overrun_q;
    logic                any_low, push, pop, full, drop;
    logic [1:0]          sel_row;
    logic [CODE_W-1:0]   push_code;

    assign any_low   = ~&row_s2_q;
    assign sel_row   = lowest_row(row_s2_q);
    assign push_code = {col_q, row_sel_q};
    assign key_col   = ~(NUM_COLS'(1) << col_q);

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_sel_d  = row_sel_q;
        scan_cnt_d = scan_cnt_q;
        db_cnt_d   = db_cnt_q;
        push       = 1'b0;
        unique case (state_q)
            StScan: begin
                if (scan_cnt_q == SCAN_LAST) begin
                    scan_cnt_d = '0;
                    if (any_low) begin
                        state_d   = StPressDb;
                        row_sel_d = sel_row;
                        db_cnt_d  = '0;
                    end else begin
                        col_d = next_col(col_q);
                    end
                end else begin
                    scan_cnt_d = scan_cnt_q + SCAN_W'(1);
                end
            end
            StPressDb: begin
                // Losing the latched row or a lower row taking over restarts detection.
                if (row_s2_q[row_sel_q] || (sel_row != row_sel_q)) begin
                    state_d    = StScan;
                    db_cnt_d   = '0;
                    scan_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    push     = 1'b1;
                    state_d  = StHeld;
                    db_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            StHeld: begin
                if (!any_low) begin
                    state_d  = StRelDb;
                    db_cnt_d = '0;
                end
            end
            StRelDb: begin
                if (any_low) begin
                    state_d  = StHeld;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d    = StScan;
                    col_d      = next_col(col_q);
                    scan_cnt_d = '0;
                    db_cnt_d   = '0;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            default: state_d = StScan;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StScan;
            row_s1_q   <= '1;
            row_s2_q   <= '1;
            col_q      <= '0;
            row_sel_q  <= '0;
            scan_cnt_q <= '0;
            db_cnt_q   <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_s1_q   <= key_row;
            row_s2_q   <= row_s1_q;
            col_q      <= col_d;
            row_sel_q  <= row_sel_d;
            scan_cnt_q <= scan_cnt_d;
            db_cnt_q   <= db_cnt_d;
            overrun_q  <= drop;
        end
    end

    assign pop     = key_ready && !readn;
    assign drop    = push && full && !pop;
    assign overrun = overrun_q;

`ifdef KEYPAD_FIFO_EN
    keypad_fifo u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_code),
        .pop       (pop),
        .full      (full),
        .not_empty (key_ready),
        .head      (key_code)
    );
`else
    logic [CODE_W-1:0] code_q;
    logic              ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q  <= '0;
            ready_q <= 1'b0;
        end else if (push && (!ready_q || pop)) begin
            code_q  <= push_code;
            ready_q <= 1'b1;
        end else if (pop) begin
            ready_q <= 1'b0;
        end
    end

    assign full      = ready_q;
    assign key_code  = code_q;
    assign key_ready = ready_q;
`endif

endmodule
